// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I byte-addressed load/store unit in front of a word-addressed data memory
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   req_valid/req_ready             request handshake (ready only in IDLE)
//   req_we, req_funct3              store/load select, RV32I size/sign code
//   req_addr, req_wdata             byte address, right-justified store data
//   rsp_valid, rsp_rdata, rsp_err   one-cycle completion, extended load data, reject flag
//   mem_address                     word index (zero-extended), 0 in IDLE
//   mem_write_data/enable           memory write port
//   mem_read_enable, mem_read_data  memory read port (data one edge after enable)
module load_store_unit #(
    parameter int DEPTH  = 256,
    parameter int MEM_AW = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write_enable,
    output logic        mem_read_enable,
    input  logic [31:0] mem_read_data
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LD_REQ    = 3'd1;
    localparam logic [2:0] S_LD_RESP   = 3'd2;
    localparam logic [2:0] S_ST_WR     = 3'd3;
    localparam logic [2:0] S_RMW_RD    = 3'd4;
    localparam logic [2:0] S_RMW_MERGE = 3'd5;
    localparam logic [2:0] S_ERR       = 3'd6;

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    logic [2:0]        state;
    logic [2:0]        next_state;
    logic              lat_we;
    logic [2:0]        lat_f3;
    logic [MEM_AW+1:0] lat_addr;
    logic [31:0]       lat_wdata;

    logic        accept;
    logic        f3_bad;
    logic        range_bad;
    logic        align_bad;
    logic        req_err;
    logic        done;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign req_ready = (state == S_IDLE) && rst_n;
    assign accept    = req_valid && req_ready;

    // Error priority: funct3 first, then range, then alignment.
    always_comb begin
        f3_bad = 1'b0;
        if (req_we)
            f3_bad = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
        else
            f3_bad = !(req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end

    // Word index must fall inside the memory; equivalent to the upper address bits being zero.
    assign range_bad = ({2'b00, req_addr[31:2]} >= DEPTH_W);
    // funct3[1:0] is the access size for every legal code.
    assign align_bad = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    assign req_err   = f3_bad || range_bad || align_bad;

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (req_err)                    next_state = S_ERR;
                    else if (!req_we)               next_state = S_LD_REQ;
                    else if (req_funct3 == 3'b010)  next_state = S_ST_WR;
                    else                            next_state = S_RMW_RD;
                end
            end
            S_LD_REQ:    next_state = S_LD_RESP;
            S_RMW_RD:    next_state = S_RMW_MERGE;
            S_LD_RESP,
            S_ST_WR,
            S_RMW_MERGE,
            S_ERR:       next_state = S_IDLE;
            default:     next_state = S_IDLE;
        endcase
    end

    // Lane selection and extension of the returned word.
    always_comb begin
        byte_sel = mem_read_data[{lat_addr[1:0], 3'b000} +: 8];
        half_sel = lat_addr[1] ? mem_read_data[31:16] : mem_read_data[15:0];
        case (lat_f3)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_ext = {24'h0, byte_sel};
            3'b101:  load_ext = {16'h0, half_sel};
            default: load_ext = mem_read_data;
        endcase
    end

    // Sub-word store: overwrite only the addressed lane of the word just read.
    always_comb begin
        merged = mem_read_data;
        if (lat_f3[1:0] == 2'b00)
            merged[{lat_addr[1:0], 3'b000} +: 8] = lat_wdata[7:0];
        else
            merged[{lat_addr[1], 4'b0000} +: 16] = lat_wdata[15:0];
    end

    // Strobes are gated by rst_n so a reset in RMW_MERGE aborts the write.
    assign mem_read_enable  = rst_n && ((state == S_LD_REQ) || (state == S_RMW_RD));
    assign mem_write_enable = rst_n && ((state == S_ST_WR)  || (state == S_RMW_MERGE));
    assign mem_write_data   = (state == S_RMW_MERGE) ? merged : lat_wdata;
    assign mem_address      = (state == S_IDLE) ? 32'h0
                            : {{(32-MEM_AW){1'b0}}, lat_addr[MEM_AW+1:2]};

    assign done = (state == S_LD_RESP) || (state == S_ST_WR) ||
                  (state == S_RMW_MERGE) || (state == S_ERR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            lat_we    <= 1'b0;
            lat_f3    <= 3'b000;
            lat_addr  <= '0;
            lat_wdata <= 32'h0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'h0;
        end else begin
            state     <= next_state;
            rsp_valid <= done;
            rsp_err   <= (state == S_ERR);
            if (done)
                rsp_rdata <= (state == S_LD_RESP) ? load_ext : 32'h0;
            if (accept) begin
                lat_we    <= req_we;
                lat_f3    <= req_funct3;
                lat_addr  <= req_addr[MEM_AW+1:0];
                lat_wdata <= req_wdata;
            end
        end
    end

    // lat_we is kept for visibility of the latched request; routing already encoded in state.
    logic unused_ok;
    assign unused_ok = lat_we;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write_enable;
    logic        mem_read_enable;
    logic [31:0] mem_read_data;

    int errors = 0;
    int checks = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int both_cnt = 0;
    logic [31:0] last_wr_addr = 32'h0;
    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    load_store_unit #(.DEPTH(256), .MEM_AW(8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_we           (req_we),
        .req_funct3       (req_funct3),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_rdata        (rsp_rdata),
        .rsp_err          (rsp_err),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_read_enable  (mem_read_enable),
        .mem_read_data    (mem_read_data)
    );

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem_read_data = 32'h0;
    end

    always @(posedge clk) begin
        if (mem_write_enable) begin
            mem[mem_address[7:0]] <= mem_write_data;
            last_wr_addr          <= mem_address;
        end
        if (mem_read_enable)
            mem_read_data <= mem[mem_address[7:0]];
    end

    always @(posedge clk) begin
        if (mem_read_enable)  rd_cnt++;
        if (mem_write_enable) wr_cnt++;
        if (mem_read_enable && mem_write_enable) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called #1 after an edge with the unit idle; returns #1 after the rsp_valid edge.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input string tag, input logic [31:0] exp_d,
                          input logic exp_e, input int exp_lat, input int exp_rd,
                          input int exp_wr, input logic hold);
        int lat;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        rd_cnt = 0; wr_cnt = 0; both_cnt = 0;
        check({tag, ".ready"}, {31'h0, req_ready}, 32'h1);
        @(posedge clk); #1;
        if (!hold) req_valid = 1'b0;
        check({tag, ".busy"}, {31'h0, req_ready}, 32'h0);
        lat = 1;
        while (!rsp_valid && lat < 16) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".rsp_valid"}, {31'h0, rsp_valid}, 32'h1);
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".rdata"}, rsp_rdata, exp_d);
        check({tag, ".err"}, {31'h0, rsp_err}, {31'h0, exp_e});
        check({tag, ".rd_strobes"}, 32'(rd_cnt), 32'(exp_rd));
        check({tag, ".wr_strobes"}, 32'(wr_cnt), 32'(exp_wr));
        check({tag, ".exclusive"}, 32'(both_cnt), 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.ready_low", {31'h0, req_ready}, 32'h0);
        rst_n = 1'b1;
        #1;
        check("rst.ready", {31'h0, req_ready}, 32'h1);
        check("rst.rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst.rsp_err", {31'h0, rsp_err}, 32'h0);
        check("rst.rsp_rdata", rsp_rdata, 32'h0);
        check("rst.strobes", {30'h0, mem_read_enable, mem_write_enable}, 32'h0);
        check("rst.mem_address", mem_address, 32'h0);

        // Word store then load back
        do_req(1, 3'b010, 32'h10, 32'hDEADBEEF, "sw10", 32'h0, 0, 2, 0, 1, 0);
        check("sw10.wr_addr", last_wr_addr, 32'h4);
        do_req(0, 3'b010, 32'h10, 32'h0, "lw10", 32'hDEADBEEF, 0, 3, 1, 0, 0);

        // Lane selection and extension
        do_req(1, 3'b010, 32'h10, 32'h80FF7F01, "sw10b", 32'h0, 0, 2, 0, 1, 0);
        do_req(0, 3'b000, 32'h11, 32'h0, "lb11",  32'h0000007F, 0, 3, 1, 0, 0);
        do_req(0, 3'b000, 32'h13, 32'h0, "lb13",  32'hFFFFFF80, 0, 3, 1, 0, 0);
        do_req(0, 3'b100, 32'h12, 32'h0, "lbu12", 32'h000000FF, 0, 3, 1, 0, 0);
        do_req(0, 3'b001, 32'h12, 32'h0, "lh12",  32'hFFFF80FF, 0, 3, 1, 0, 0);
        do_req(0, 3'b101, 32'h10, 32'h0, "lhu10", 32'h00007F01, 0, 3, 1, 0, 0);

        // Sub-word stores via read-modify-write
        do_req(1, 3'b010, 32'h20, 32'h11223344, "sw20", 32'h0, 0, 2, 0, 1, 0);
        do_req(1, 3'b000, 32'h21, 32'h000000AB, "sb21", 32'h0, 0, 3, 1, 1, 0);
        check("sb21.mem", mem[8], 32'h1122AB44);
        do_req(1, 3'b001, 32'h22, 32'h0000CDEF, "sh22", 32'h0, 0, 3, 1, 1, 0);
        check("sh22.mem", mem[8], 32'hCDEFAB44);
        do_req(0, 3'b010, 32'h20, 32'h0, "lw20", 32'hCDEFAB44, 0, 3, 1, 0, 0);

        // Rejected requests
        do_req(0, 3'b010, 32'h02,  32'h0, "err_lw02",  32'h0, 1, 2, 0, 0, 0);
        do_req(0, 3'b001, 32'h03,  32'h0, "err_lh03",  32'h0, 1, 2, 0, 0, 0);
        do_req(0, 3'b010, 32'h400, 32'h0, "err_lw400", 32'h0, 1, 2, 0, 0, 0);
        do_req(0, 3'b011, 32'h0,   32'h0, "err_ld011", 32'h0, 1, 2, 0, 0, 0);
        do_req(1, 3'b100, 32'h0,   32'h0, "err_st100", 32'h0, 1, 2, 0, 0, 0);
        do_req(0, 3'b010, 32'h3FC, 32'h0, "lw3fc",     32'h0, 0, 3, 1, 0, 0);

        // Reset in RMW_MERGE aborts the write
        do_req(1, 3'b010, 32'h30, 32'h55667788, "sw30", 32'h0, 0, 2, 0, 1, 0);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h31; req_wdata = 32'h0;
        wr_cnt = 0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort.we", {31'h0, mem_write_enable}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("abort.ready", {31'h0, req_ready}, 32'h1);
        check("abort.rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("abort.wr_strobes", 32'(wr_cnt), 32'h0);
        check("abort.mem", mem[12], 32'h55667788);
        do_req(0, 3'b010, 32'h30, 32'h0, "lw30", 32'h55667788, 0, 3, 1, 0, 0);

        // Back-to-back with req_valid held high
        do_req(1, 3'b010, 32'h40, 32'h12345678, "b2b_sw", 32'h0, 0, 2, 0, 1, 1);
        do_req(0, 3'b010, 32'h40, 32'h0, "b2b_lw", 32'h12345678, 0, 3, 1, 0, 1);
        do_req(0, 3'b000, 32'h41, 32'h0, "b2b_lb", 32'h00000056, 0, 3, 1, 0, 1);
        do_req(0, 3'b010, 32'h02, 32'h0, "b2b_err", 32'h0, 1, 2, 0, 0, 1);
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("end.rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("end.rdata_hold", rsp_rdata, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
